// File: rtl/catch_round_ctrl_pkg.sv
// ============================================================================
// Module      : catch_pkg
// Description : Shared encodings and helpers for the catch game round
//               controller: ball state codes, controller phases, tone timing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package catch_pkg;

   // Ball state machine encodings, as seen on the ball_state input
   typedef enum logic [1:0] {
      BS_HELD1  = 2'd0,
      BS_HELD2  = 2'd1,
      BS_FLYING = 2'd2,
      BS_FREE   = 2'd3
   } ball_state_t;

   // Controller phases, exported on the phase output
   typedef enum logic [2:0] {
      PH_IDLE  = 3'd0,
      PH_SERVE = 3'd1,
      PH_PLAY  = 3'd2,
      PH_MISS  = 3'd3,
      PH_OVER  = 3'd4
   } phase_t;

   // Tone half-period in vclocks (27 MHz / 27000 = 1 kHz)
   localparam int c_SOUND_HALF_PERIOD = 13500;
   // Tone durations in frames
   localparam logic [4:0] c_SOUND_CATCH_FRAMES = 5'd6;
   localparam logic [4:0] c_SOUND_MISS_FRAMES  = 5'd30;

   // Saturating increment for 8-bit counters
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Saturating increment for 4-bit scores
   function automatic logic [3:0] sat_inc4(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/catch_round_ctrl_frame_timer.sv
// ============================================================================
// Module      : frame_timer
// Description : vsync falling-edge frame tick plus a loadable frame
//               down-counter; done flags the tick that brings it to zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module frame_timer (
   input  logic       vclock,
   input  logic       reset_n,
   input  logic       vsync,
   input  logic       load,
   input  logic [7:0] load_val,
   output logic       tick,
   output logic       done
);

   logic       r_vsync_prev;
   logic [7:0] r_cnt;

   // Previous vsync sample; idles high so reset does not fake an edge
   always_ff @(posedge vclock or negedge reset_n) begin
      if (!reset_n) r_vsync_prev <= 1'b1;
      else          r_vsync_prev <= vsync;
   end

   assign tick = r_vsync_prev & ~vsync;

   // Load wins over a coincident tick so a phase always gets its full count
   always_ff @(posedge vclock or negedge reset_n) begin
      if (!reset_n)                    r_cnt <= 8'd0;
      else if (load)                   r_cnt <= load_val;
      else if (tick && r_cnt != 8'd0)  r_cnt <= r_cnt - 8'd1;
   end

   assign done = tick & (r_cnt == 8'd1);

endmodule

`default_nettype wire

// File: rtl/catch_round_ctrl.sv
// ============================================================================
// Module      : catch_round_ctrl
// Description : Round and score sequencer for the catch game. Arms a serve
//               after a frame countdown, detects rallies and misses, keeps
//               per-player score and declares game over.
//               Optional tone generator: define CATCH_ROUND_SOUND_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module catch_round_ctrl #(
   parameter int          SERVE_FRAMES  = 90,
   parameter int          MISS_FRAMES   = 60,
   parameter int          FLIGHT_FRAMES = 180,
   parameter logic [15:0] FLOOR_Y       = 16'd600,
   parameter int          WIN_SCORE     = 7
) (
   input  logic        vclock,
   input  logic        reset_n,
   input  logic        vsync,
   input  logic        start,
   input  logic        catch_event,
   input  logic        throw_event,
   input  logic [1:0]  ball_state,
   input  logic [15:0] ball_y,
   output logic        ball_rst,
   output logic [2:0]  phase,
   output logic        serve_player,
   output logic [3:0]  score1,
   output logic [3:0]  score2,
   output logic [7:0]  rally,
   output logic        game_over,
   output logic        sound
);

   import catch_pkg::*;

   localparam logic [7:0] c_SERVE_LD   = 8'(SERVE_FRAMES);
   localparam logic [7:0] c_MISS_LD    = 8'(MISS_FRAMES);
   localparam logic [7:0] c_FLIGHT_LIM = 8'(FLIGHT_FRAMES);
   localparam logic [3:0] c_WIN        = 4'(WIN_SCORE);

   phase_t     r_phase, w_phase_nxt;
   logic       w_load, w_clear_game, w_enter_play;
   logic [7:0] w_load_val;
   logic       w_tick, w_done;
   logic       w_flying, w_miss;
   logic       r_ball_rst, r_game_over, r_serve_player, r_last_holder;
   logic [3:0] r_score1, r_score2;
   logic [7:0] r_rally, r_flight_cnt;

   // One shared frame counter serves both the SERVE and MISS countdowns
   frame_timer u_frame_timer (
      .vclock   (vclock),
      .reset_n  (reset_n),
      .vsync    (vsync),
      .load     (w_load),
      .load_val (w_load_val),
      .tick     (w_tick),
      .done     (w_done)
   );

   // A catch in the same cycle as a drop/timeout rescues the ball
   assign w_flying = (ball_state == BS_FLYING);
   assign w_miss   = (r_phase == PH_PLAY) & ~catch_event &
                     ((w_flying & (ball_y >= FLOOR_Y)) | (r_flight_cnt >= c_FLIGHT_LIM));

   // Phase state register
   always_ff @(posedge vclock or negedge reset_n) begin
      if (!reset_n) r_phase <= PH_IDLE;
      else          r_phase <= w_phase_nxt;
   end

   // Next phase, countdown load requests and game restart
   always_comb begin
      w_phase_nxt  = r_phase;
      w_load       = 1'b0;
      w_load_val   = c_SERVE_LD;
      w_clear_game = 1'b0;
      case (r_phase)
         PH_IDLE: begin
            if (start) begin
               w_phase_nxt = PH_SERVE;
               w_load      = 1'b1;
            end
         end
         PH_SERVE: begin
            if (w_done) w_phase_nxt = PH_PLAY;
         end
         PH_PLAY: begin
            if (w_miss) begin
               w_phase_nxt = PH_MISS;
               w_load      = 1'b1;
               w_load_val  = c_MISS_LD;
            end
         end
         PH_MISS: begin
            if (w_done) begin
               if (r_score1 == c_WIN || r_score2 == c_WIN) begin
                  w_phase_nxt = PH_OVER;
               end else begin
                  w_phase_nxt = PH_SERVE;
                  w_load      = 1'b1;
               end
            end
         end
         PH_OVER: begin
            if (start) begin
               w_phase_nxt  = PH_SERVE;
               w_load       = 1'b1;
               w_clear_game = 1'b1;
            end
         end
         default: w_phase_nxt = PH_IDLE;
      endcase
   end

   assign w_enter_play = (r_phase != PH_PLAY) && (w_phase_nxt == PH_PLAY);

   // Round datapath: holder tracking, flight timer, rally and scoring
   always_ff @(posedge vclock or negedge reset_n) begin
      if (!reset_n) begin
         r_ball_rst     <= 1'b1;
         r_game_over    <= 1'b0;
         r_serve_player <= 1'b0;
         r_last_holder  <= 1'b0;
         r_score1       <= 4'd0;
         r_score2       <= 4'd0;
         r_rally        <= 8'd0;
         r_flight_cnt   <= 8'd0;
      end else begin
         // Registered from the next phase so they move with phase itself
         r_ball_rst  <= (w_phase_nxt != PH_PLAY);
         r_game_over <= (w_phase_nxt == PH_OVER);
         if (w_enter_play) begin
            r_last_holder <= r_serve_player;
            r_flight_cnt  <= 8'd0;
         end else if (r_phase == PH_PLAY) begin
            if (ball_state == BS_HELD1)      r_last_holder <= 1'b0;
            else if (ball_state == BS_HELD2) r_last_holder <= 1'b1;
            if (throw_event)                 r_flight_cnt <= 8'd0;
            else if (w_tick && w_flying)     r_flight_cnt <= sat_inc8(r_flight_cnt);
            if (catch_event) begin
               r_rally <= sat_inc8(r_rally);
            end else if (w_miss) begin
               // The last holder dropped it: the other player scores and
               // the dropping player serves next
               if (r_last_holder) r_score1 <= sat_inc4(r_score1);
               else               r_score2 <= sat_inc4(r_score2);
               r_serve_player <= r_last_holder;
               r_rally        <= 8'd0;
            end
         end
         if (w_clear_game) begin
            r_score1 <= 4'd0;
            r_score2 <= 4'd0;
            r_rally  <= 8'd0;
         end
      end
   end

   assign ball_rst     = r_ball_rst;
   assign phase        = r_phase;
   assign serve_player = r_serve_player;
   assign score1       = r_score1;
   assign score2       = r_score2;
   assign rally        = r_rally;
   assign game_over    = r_game_over;

`ifdef CATCH_ROUND_SOUND_EN
   logic [4:0]  r_snd_dur;
   logic [13:0] r_snd_div;
   logic        r_sound;

   // Tone duration in frames; a new event restarts it
   always_ff @(posedge vclock or negedge reset_n) begin
      if (!reset_n)                       r_snd_dur <= 5'd0;
      else if (catch_event)               r_snd_dur <= c_SOUND_CATCH_FRAMES;
      else if (w_miss)                    r_snd_dur <= c_SOUND_MISS_FRAMES;
      else if (w_tick && r_snd_dur != 0)  r_snd_dur <= r_snd_dur - 5'd1;
   end

   // Square wave toggling every half-period while the duration is live
   always_ff @(posedge vclock or negedge reset_n) begin
      if (!reset_n) begin
         r_snd_div <= 14'd0;
         r_sound   <= 1'b0;
      end else if (r_snd_dur == 5'd0) begin
         r_snd_div <= 14'd0;
         r_sound   <= 1'b0;
      end else if (r_snd_div == 14'(c_SOUND_HALF_PERIOD - 1)) begin
         r_snd_div <= 14'd0;
         r_sound   <= ~r_sound;
      end else begin
         r_snd_div <= r_snd_div + 14'd1;
      end
   end

   assign sound = r_sound;
`else
   assign sound = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_catch_round_ctrl.sv
// ============================================================================
// Module      : tb_catch_round_ctrl
// Description : Self-checking bench for catch_round_ctrl: a frame-level
//               reference model compared every cycle, plus directed rounds
//               with hand-computed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_catch_round_ctrl;

   localparam int SERVE_N  = 90;
   localparam int MISS_N   = 60;
   localparam int FLIGHT_N = 180;
   localparam int FLOOR    = 600;
   localparam int WIN      = 7;
   localparam int FRAME    = 8;   // vclocks per bench frame

   logic        vclock = 1'b0;
   logic        reset_n = 1'b0;
   logic        vsync = 1'b1;
   logic        start = 1'b0;
   logic        catch_event = 1'b0;
   logic        throw_event = 1'b0;
   logic [1:0]  ball_state = 2'd0;
   logic [15:0] ball_y = 16'd0;
   logic        ball_rst;
   logic [2:0]  phase;
   logic        serve_player;
   logic [3:0]  score1, score2;
   logic [7:0]  rally;
   logic        game_over;
   logic        sound;

   int n_checks = 0;
   int n_errors = 0;
   int falls = 0;
   bit gen_en = 1'b0;

   catch_round_ctrl dut (
      .vclock       (vclock),
      .reset_n      (reset_n),
      .vsync        (vsync),
      .start        (start),
      .catch_event  (catch_event),
      .throw_event  (throw_event),
      .ball_state   (ball_state),
      .ball_y       (ball_y),
      .ball_rst     (ball_rst),
      .phase        (phase),
      .serve_player (serve_player),
      .score1       (score1),
      .score2       (score2),
      .rally        (rally),
      .game_over    (game_over),
      .sound        (sound)
   );

   always #5 vclock = ~vclock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- frame-level reference model ----------------
   int m_ph = 0, m_left = 0, m_fc = 0, m_lh = 0, m_sp = 0;
   int m_s1 = 0, m_s2 = 0, m_rally = 0;
   bit m_prev = 1'b1;

   initial forever begin
      @(posedge vclock or negedge reset_n);
      if (!reset_n) begin
         m_ph = 0; m_left = 0; m_fc = 0; m_lh = 0; m_sp = 0;
         m_s1 = 0; m_s2 = 0; m_rally = 0; m_prev = 1'b1;
      end else begin
         bit tk, flying, miss;
         tk = m_prev && !vsync;
         m_prev = vsync;
         flying = (ball_state == 2'd2);
         case (m_ph)
            0: if (start) begin m_ph = 1; m_left = SERVE_N; end
            1: if (tk) begin
                  m_left = m_left - 1;
                  if (m_left == 0) begin m_ph = 2; m_lh = m_sp; m_fc = 0; end
               end
            2: begin
                  miss = !catch_event && ((flying && ball_y >= FLOOR) || m_fc >= FLIGHT_N);
                  if (catch_event) m_rally = (m_rally < 255) ? m_rally + 1 : 255;
                  else if (miss) begin
                     if (m_lh == 0) m_s2 = (m_s2 < 15) ? m_s2 + 1 : 15;
                     else           m_s1 = (m_s1 < 15) ? m_s1 + 1 : 15;
                     m_sp = m_lh; m_rally = 0; m_ph = 3; m_left = MISS_N;
                  end
                  if (ball_state == 2'd0)      m_lh = 0;
                  else if (ball_state == 2'd1) m_lh = 1;
                  if (throw_event)        m_fc = 0;
                  else if (tk && flying)  m_fc = (m_fc < 255) ? m_fc + 1 : 255;
               end
            3: if (tk) begin
                  m_left = m_left - 1;
                  if (m_left == 0) begin
                     if (m_s1 == WIN || m_s2 == WIN) m_ph = 4;
                     else begin m_ph = 1; m_left = SERVE_N; end
                  end
               end
            4: if (start) begin
                  m_s1 = 0; m_s2 = 0; m_rally = 0; m_ph = 1; m_left = SERVE_N;
               end
            default: m_ph = 0;
         endcase
      end
   end

   // Every-cycle comparison against the model, away from the active edge
   initial forever begin
      @(negedge vclock);
      chk("phase", phase, m_ph);
      chk("ball_rst", ball_rst, (m_ph != 2) ? 1 : 0);
      chk("game_over", game_over, (m_ph == 4) ? 1 : 0);
      chk("serve_player", serve_player, m_sp);
      chk("score1", score1, m_s1);
      chk("score2", score2, m_s2);
      chk("rally", rally, m_rally);
`ifndef CATCH_ROUND_SOUND_EN
      chk("sound", sound, 0);
`endif
   end

   // Frame generator: vsync low for 2 of every FRAME cycles
   initial begin
      int k;
      k = 0;
      forever begin
         @(posedge vclock);
         #2;
         if (gen_en) begin
            if (k % FRAME == 0) begin vsync = 1'b0; falls++; end
            else if (k % FRAME == 2) vsync = 1'b1;
            k++;
         end
      end
   end

   task automatic cyc(input int n = 1);
      repeat (n) begin @(posedge vclock); #1; end
   endtask

   task automatic wait_phase(input int p, input int max_cyc, input string tag);
      int n;
      n = 0;
      while (phase !== 3'(p) && n < max_cyc) begin cyc(); n++; end
      chk(tag, phase, p);
   endtask

   task automatic sync_frame();
      int f, n;
      f = falls; n = 0;
      while (falls == f && n < 4 * FRAME) begin cyc(); n++; end
      cyc(2);
   endtask

   task automatic summary();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
   endtask

   initial begin
      #3_000_000;
      n_errors++;
      $display("FAIL watchdog: got timeout expected completion");
      summary();
      $finish;
   end

   // ---------------- directed stimulus ----------------
   initial begin
      int f0;
      cyc(3);
      chk("rst_phase", phase, 0);
      chk("rst_ball_rst", ball_rst, 1);
      chk("rst_score1", score1, 0);
      chk("rst_rally", rally, 0);
      reset_n = 1'b1;
      gen_en  = 1'b1;
      cyc(10);
      chk("idle_hold", phase, 0);

      // Start: SERVE for exactly 90 frames, then PLAY
      sync_frame();
      f0 = falls;
      start = 1'b1; cyc(); start = 1'b0;
      chk("serve_entry", phase, 1);
      chk("serve_ball_rst", ball_rst, 1);
      wait_phase(2, (SERVE_N + 10) * FRAME, "reach_play");
      chk("serve_frames", falls - f0, 90);
      chk("play_ball_rst", ball_rst, 0);

      // Three catches, then a drop at the floor by player 1
      repeat (3) begin catch_event = 1'b1; cyc(); catch_event = 1'b0; cyc(); end
      chk("rally3", rally, 3);
      start = 1'b1; cyc(); start = 1'b0;
      chk("start_ignored", phase, 2);
      ball_state = 2'd2; ball_y = 16'd600; throw_event = 1'b1;
      cyc();
      throw_event = 1'b0; ball_state = 2'd0; ball_y = 16'd0;
      chk("drop_phase", phase, 3);
      chk("drop_rally", rally, 0);
      chk("drop_score2", score2, 1);
      chk("drop_serve", serve_player, 0);
      f0 = falls;
      wait_phase(1, (MISS_N + 10) * FRAME, "miss_to_serve");
      chk("miss_frames", falls - f0, 60);

      // Timeout miss after 180 frames of flight below the floor
      wait_phase(2, (SERVE_N + 10) * FRAME, "play2");
      ball_state = 2'd2; ball_y = 16'd100; throw_event = 1'b1;
      f0 = falls;
      cyc();
      throw_event = 1'b0;
      wait_phase(3, (FLIGHT_N + 10) * FRAME, "timeout_miss");
      chk("timeout_frames", falls - f0, 180);
      chk("timeout_score2", score2, 2);
      ball_state = 2'd0; ball_y = 16'd0;

      // Catch coincident with a below-floor ball: catch wins
      wait_phase(2, (MISS_N + SERVE_N + 10) * FRAME, "play3");
      ball_state = 2'd2; ball_y = 16'd650; catch_event = 1'b1;
      cyc();
      catch_event = 1'b0; ball_state = 2'd1; ball_y = 16'd0;
      chk("coinc_phase", phase, 2);
      chk("coinc_rally", rally, 1);
      cyc();
      ball_state = 2'd2; ball_y = 16'd650;
      cyc();
      ball_state = 2'd1; ball_y = 16'd0;
      chk("p2_drop_score1", score1, 1);
      chk("p2_drop_serve", serve_player, 1);

      // Six more player-2 drops take score1 to the winning score
      for (int i = 0; i < 6; i++) begin
         wait_phase(2, (MISS_N + SERVE_N + 10) * FRAME, "play_loop");
         cyc();
         ball_state = 2'd2; ball_y = 16'd600;
         cyc();
         ball_state = 2'd1; ball_y = 16'd0;
      end
      chk("win_score1", score1, 7);
      chk("win_still_miss", phase, 3);
      wait_phase(4, (MISS_N + 10) * FRAME, "game_over_phase");
      chk("game_over_flag", game_over, 1);
      chk("over_score2", score2, 2);
      start = 1'b1; cyc(); start = 1'b0;
      chk("restart_phase", phase, 1);
      chk("restart_score1", score1, 0);
      chk("restart_score2", score2, 0);
      chk("restart_game_over", game_over, 0);

      // Asynchronous reset in the middle of play
      wait_phase(2, (SERVE_N + 10) * FRAME, "play_final");
      catch_event = 1'b1; cyc(); catch_event = 1'b0;
      chk("pre_rst_rally", rally, 1);
      chk("pre_rst_serve", serve_player, 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_phase", phase, 0);
      chk("async_ball_rst", ball_rst, 1);
      chk("async_rally", rally, 0);
      chk("async_serve", serve_player, 0);
      chk("async_game_over", game_over, 0);
      cyc(2);
      reset_n = 1'b1;
      cyc(5);
      chk("post_rst_idle", phase, 0);
      summary();
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/catch_round_ctrl.md
# catch_round_ctrl

Round and score sequencer for the catch game. Sits beside the ball state machine and owns its reset: it arms a serve after a countdown, watches catch/throw events and ball state to detect rallies and misses, keeps per-player score, and declares game over. All timing is counted in frames derived from the XVGA vsync. Outputs feed the ball state machine's reset and the overlay/sound logic.

## Interface
Parameters:
- SERVE_FRAMES, 90: frames of countdown before play starts.
- MISS_FRAMES, 60: frames of pause after a miss.
- FLIGHT_FRAMES, 180: maximum frames in FLYING before a timeout miss is declared.
- FLOOR_Y, 16'd600: ball_y at or beyond which a flying ball counts as dropped.
- WIN_SCORE, 7: score that ends the game (1..15).

Ports:
- vclock  in  1  27 MHz pixel clock.
- reset_n  in  1  asynchronous, active-low reset.
- vsync  in  1  XVGA vertical sync, active low, vclock domain.
- start  in  1  single-cycle pulse, debounced start button.
- catch_event  in  1  single-cycle pulse from the ball state machine.
- throw_event  in  1  single-cycle pulse from the ball state machine.
- ball_state  in  2  0 = HELD1, 1 = HELD2, 2 = FLYING, 3 = FREE.
- ball_y  in  16  ball global y coordinate, unsigned.
- ball_rst  out  1  active-high reset to the ball state machine.
- phase  out  3  current controller state.
- serve_player  out  1  0 = player 1, 1 = player 2.
- score1, score2  out  4  player scores.
- rally  out  8  catches in the current rally.
- game_over  out  1  high in GAME_OVER.
- sound  out  1  tone output (see Configuration).

## Operation
- Frame tick: a registered copy of vsync; tick = prev & ~vsync, asserted one cycle after the falling edge is sampled.
- States:
  - IDLE: waits for start. On start, go to SERVE.
  - SERVE: load frame_cnt with SERVE_FRAMES and decrement on each tick. At 0, go to PLAY.
  - PLAY: runs the rally (below).
  - MISS: load MISS_FRAMES and count down. At 0, go to GAME_OVER if either score equals WIN_SCORE, else go to SERVE.
  - GAME_OVER: on start, clear scores and rally, then go to SERVE.
- ball_rst is 1 in every state except PLAY.
- last_holder register:
  - Updated in PLAY whenever ball_state is HELD1 (set 0) or HELD2 (set 1).
  - Loaded from serve_player on entry to PLAY.
- Entering PLAY clears flight_cnt.
- PLAY rules:
  - catch_event: rally increments, saturating at 255.
  - throw_event: flight_cnt is cleared.
  - flight_cnt increments on each tick while ball_state == FLYING, saturating at 255.
- Miss, declared in PLAY when either holds:
  - ball_state == FLYING and ball_y >= FLOOR_Y.
  - flight_cnt >= FLIGHT_FRAMES.
- On a miss:
  - The opponent of last_holder scores +1; scores saturate at 15.
  - serve_player <= the player who missed.
  - rally is cleared.
  - Go to MISS.
- Simultaneous events:
  - catch_event in the same cycle as a miss condition: the catch wins, no miss is declared, rally increments.
  - start outside IDLE/GAME_OVER is ignored.
- serve_player resets to 0.

## Timing
- Reset values (async, reset_n low):
  - phase = IDLE, ball_rst = 1, serve_player = 0.
  - score1 = score2 = 0, rally = 0, game_over = 0, sound = 0.
  - All counters 0, the vsync copy = 1.
- All outputs are registered and change one vclock after the causing input or tick.
- ball_rst falls in the same cycle phase becomes PLAY, and rises in the same cycle phase leaves PLAY.
- SERVE lasts exactly SERVE_FRAMES ticks. PLAY is entered on the cycle after the tick that brings the count to 0.
- Reset asserted mid-round forces IDLE immediately. It does not wait for a frame boundary.

## Configuration
- CATCH_ROUND_SOUND_EN defined:
  - sound is a square wave toggling every 13500 vclocks (about 1 kHz).
  - It runs for 6 ticks after each catch_event, and for 30 ticks after a miss.
  - A new event restarts the duration.
- Not defined: sound is tied to 0 and the tone logic is absent.

## Structure
- Package catch_pkg holds:
  - ball_state encodings BS_HELD1, BS_HELD2, BS_FLYING, BS_FREE.
  - Phase encodings PH_IDLE=0, PH_SERVE=1, PH_PLAY=2, PH_MISS=3, PH_OVER=4.
- One sub-module, frame_timer: vsync edge detector plus a loadable down-counter with a done flag. It is instantiated once and shared by SERVE and MISS.

## Test plan
- Reset then start: phase goes IDLE -> SERVE. ball_rst stays 1 for exactly 90 vsync falls, then phase = PLAY and ball_rst = 0.
- In PLAY with last_holder = 0, apply 3 catch pulses, then ball_state = FLYING with ball_y = 600: rally reads 3 and then 0, score2 = 1, serve_player = 0, phase = MISS for 60 frames, then SERVE.
- FLYING with ball_y = 100 for 180 frames: timeout miss is declared at tick 180.
- catch_event coincident with ball_y = 650: no miss, rally +1, phase stays PLAY.
- Drive score1 to 6, then one more miss by player 2: after the MISS pause, phase = GAME_OVER and game_over = 1. start clears the scores and enters SERVE.
- reset_n pulsed low during PLAY: all outputs return to reset values asynchronously. With CATCH_ROUND_SOUND_EN, a catch gives sound toggling with a 13500-cycle half-period for 6 frames.
